// File: rtl/biquad_coef_loader_pkg.sv
// Shared definitions for the biquad coefficient loader and the filter datapath.
package biquad_coef_loader_pkg;

    // Coefficient word format: signed S1.8, two integer bits and eight fractional bits.
    localparam int CW    = 10;
    localparam int WIC   = 2;
    localparam int WFC   = 8;
    localparam int NCOEF = 5;

    // Position of each coefficient within a frame and within the shadow bank.
    localparam logic [2:0] IDX_B0 = 3'd0;
    localparam logic [2:0] IDX_B1 = 3'd1;
    localparam logic [2:0] IDX_B2 = 3'd2;
    localparam logic [2:0] IDX_A1 = 3'd3;
    localparam logic [2:0] IDX_A2 = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/biquad_coef_loader_if.sv
// Valid/ready coefficient stream carrying one framed S1.8 word per transfer.
interface biquad_coef_loader_if;
    import biquad_coef_loader_pkg::*;

    logic [CW-1:0] s_data;
    logic          s_valid;
    logic          s_first;
    logic          s_ready;

    modport master (output s_data, output s_valid, output s_first, input s_ready);
    modport slave  (input s_data, input s_valid, input s_first, output s_ready);

endinterface

// File: rtl/biquad_coef_loader_coef_shadow_bank.sv
// Shadow coefficient bank filled word by word, copied in one edge into the active set.
module biquad_coef_loader_coef_shadow_bank
    import biquad_coef_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [2:0]           wr_idx,
    input  logic [CW-1:0]        wr_data,
    input  logic                 commit,
    output logic signed [CW-1:0] b0,
    output logic signed [CW-1:0] b1,
    output logic signed [CW-1:0] b2,
    output logic signed [CW-1:0] a1,
    output logic signed [CW-1:0] a2
);

    logic [CW-1:0] shadow [NCOEF];
    logic [CW-1:0] active [NCOEF];

    // Indexed shadow write; whole-bank copy to the active set on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow[wr_idx] <= wr_data;
            end
            if (commit) begin
                for (int i = 0; i < NCOEF; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    assign b0 = active[IDX_B0];
    assign b1 = active[IDX_B1];
    assign b2 = active[IDX_B2];
    assign a1 = active[IDX_A1];
    assign a2 = active[IDX_A2];

endmodule

// File: rtl/biquad_coef_loader.sv
// Coefficient loader: framing FSM, inter-word timeout and atomic commit on the sample strobe.
//   state | meaning
//   IDLE  | waiting for a b0 word (s_first); stray words are dropped with err_frame
//   LOAD  | collecting b1..a2; s_first restarts the frame, silence aborts it
//   PEND  | full set in shadow, input stalled until sample_strobe commits it
module biquad_coef_loader
    import biquad_coef_loader_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    biquad_coef_loader_if.slave  s,
    input  logic                 sample_strobe,
    output logic signed [CW-1:0] b0,
    output logic signed [CW-1:0] b1,
    output logic signed [CW-1:0] b2,
    output logic signed [CW-1:0] a1,
    output logic signed [CW-1:0] a2,
    output logic                 coef_valid,
    output logic                 commit_pulse,
    output logic                 err_frame,
    output logic                 busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic          err_nxt;
    logic          commit_nxt;
    logic          wr_en;
    logic [2:0]    wr_idx;
    logic          xfer;

    assign s.s_ready = (state != PEND);
    assign busy      = (state != IDLE);
    assign xfer      = s.s_valid & s.s_ready;

    // State, frame index, timeout count and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            tmo          <= '0;
            err_frame    <= 1'b0;
            commit_pulse <= 1'b0;
            coef_valid   <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            tmo          <= tmo_nxt;
            err_frame    <= err_nxt;
            commit_pulse <= commit_nxt;
            if (commit_nxt) begin
                coef_valid <= 1'b1;
            end
        end
    end

    // Next-state decode; error and commit come from disjoint states so they never coincide.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        tmo_nxt    = tmo;
        err_nxt    = 1'b0;
        commit_nxt = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = IDX_B0;
        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (s.s_first) begin
                        wr_en     = 1'b1;
                        wr_idx    = IDX_B0;
                        idx_nxt   = IDX_B1;
                        tmo_nxt   = '0;
                        state_nxt = LOAD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    tmo_nxt = '0;
                    wr_en   = 1'b1;
                    if (s.s_first) begin
                        // A new b0 mid-frame abandons the partial set and restarts.
                        err_nxt = 1'b1;
                        wr_idx  = IDX_B0;
                        idx_nxt = IDX_B1;
                    end else begin
                        wr_idx = idx;
                        if (idx == IDX_A2) begin
                            idx_nxt   = IDX_B0;
                            state_nxt = PEND;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end
                end else if (tmo == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    idx_nxt   = IDX_B0;
                    tmo_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                end
            end
            PEND: begin
                if (sample_strobe) begin
                    commit_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = IDX_B0;
            end
        endcase
    end

    biquad_coef_loader_coef_shadow_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (s.s_data),
        .commit  (commit_nxt),
        .b0      (b0),
        .b1      (b1),
        .b2      (b2),
        .a1      (a1),
        .a2      (a2)
    );

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed bench for the biquad coefficient loader.
module tb_biquad_coef_loader;
    import biquad_coef_loader_pkg::*;

    logic          clk;
    logic          rst;
    logic          sample_strobe;
    logic [CW-1:0] b0, b1, b2, a1, a2;
    logic          coef_valid, commit_pulse, err_frame, busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef logic [CW-1:0] set_t [NCOEF];

    biquad_coef_loader_if bus ();

    biquad_coef_loader #(.TIMEOUT(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .s             (bus.slave),
        .sample_strobe (sample_strobe),
        .b0            (b0),
        .b1            (b1),
        .b2            (b2),
        .a1            (a1),
        .a2            (a2),
        .coef_valid    (coef_valid),
        .commit_pulse  (commit_pulse),
        .err_frame     (err_frame),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input set_t e);
        chk({tag, ".b0"}, 32'(b0), 32'(e[0]));
        chk({tag, ".b1"}, 32'(b1), 32'(e[1]));
        chk({tag, ".b2"}, 32'(b2), 32'(e[2]));
        chk({tag, ".a1"}, 32'(a1), 32'(e[3]));
        chk({tag, ".a2"}, 32'(a2), 32'(e[4]));
    endtask

    // One word presented for one edge; the transfer lands on that edge.
    task automatic send(input logic [CW-1:0] w, input logic first);
        bus.s_data  = w;
        bus.s_first = first;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    task automatic send_frame(input set_t w);
        for (int i = 0; i < NCOEF; i++) begin
            send(w[i], (i == 0));
        end
    endtask

    task automatic strobe_commit(input string tag, input set_t e);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        chk({tag, ".commit"}, 32'(commit_pulse), 32'd1);
        chk({tag, ".valid"}, 32'(coef_valid), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk_out(tag, e);
        tick();
        chk({tag, ".commit_end"}, 32'(commit_pulse), 32'd0);
    endtask

    set_t zero_s = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    set_t set_a  = '{10'h100, 10'h1DF, 10'h100, 10'h2CD, 10'h06E};
    set_t set_b  = '{10'h3FF, 10'h001, 10'h200, 10'h155, 10'h2AA};
    set_t set_e  = '{10'h055, 10'h011, 10'h022, 10'h033, 10'h044};
    set_t set_c  = '{10'h0F0, 10'h10F, 10'h3C3, 10'h2A5, 10'h05A};

    initial begin
        rst           = 1'b1;
        sample_strobe = 1'b0;
        bus.s_data    = '0;
        bus.s_valid   = 1'b0;
        bus.s_first   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst.ready", 32'(bus.s_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(coef_valid), 32'd0);
        chk("rst.commit", 32'(commit_pulse), 32'd0);
        chk("rst.err", 32'(err_frame), 32'd0);
        chk_out("rst", zero_s);

        // Nominal load, strobe three cycles after the last word.
        send_frame(set_a);
        chk("nom.ready_pend", 32'(bus.s_ready), 32'd0);
        chk("nom.busy_pend", 32'(busy), 32'd1);
        chk_out("nom.pre", zero_s);
        tick();
        tick();
        strobe_commit("nom", set_a);

        // Atomicity: set B parked in PEND must not leak into the outputs.
        send_frame(set_b);
        for (int i = 0; i < 20; i++) begin
            chk("atom.ready", 32'(bus.s_ready), 32'd0);
            chk("atom.b0", 32'(b0), 32'(set_a[0]));
            chk("atom.a2", 32'(a2), 32'(set_a[4]));
            tick();
        end
        strobe_commit("atom", set_b);

        // Framing error: s_first in the middle of a frame restarts it.
        send(10'h100, 1'b1);
        chk("frm.err0", 32'(err_frame), 32'd0);
        send(10'h1DF, 1'b0);
        send(10'h055, 1'b1);
        chk("frm.err_pulse", 32'(err_frame), 32'd1);
        for (int i = 1; i < NCOEF; i++) begin
            send(set_e[i], 1'b0);
            chk("frm.err_clear", 32'(err_frame), 32'd0);
        end
        chk("frm.pend", 32'(bus.s_ready), 32'd0);
        strobe_commit("frm", set_e);

        // Timeout: two words then 255 silent cycles abort the frame.
        send(10'h123, 1'b1);
        send(10'h045, 1'b0);
        for (int i = 0; i < 254; i++) tick();
        chk("tmo.err_early", 32'(err_frame), 32'd0);
        chk("tmo.busy_early", 32'(busy), 32'd1);
        tick();
        chk("tmo.err_pulse", 32'(err_frame), 32'd1);
        chk("tmo.busy", 32'(busy), 32'd0);
        chk_out("tmo", set_e);
        tick();
        chk("tmo.err_end", 32'(err_frame), 32'd0);
        send(10'h077, 1'b0);
        chk("tmo.drop_err", 32'(err_frame), 32'd1);
        chk("tmo.drop_busy", 32'(busy), 32'd0);
        tick();
        chk("tmo.drop_end", 32'(err_frame), 32'd0);

        // Strobe coinciding with the a2 transfer is ignored.
        for (int i = 0; i < NCOEF - 1; i++) send(set_c[i], (i == 0));
        sample_strobe = 1'b1;
        send(set_c[4], 1'b0);
        sample_strobe = 1'b0;
        chk("coin.no_commit", 32'(commit_pulse), 32'd0);
        chk("coin.busy", 32'(busy), 32'd1);
        chk_out("coin.hold", set_e);
        tick();
        chk("coin.still_pend", 32'(commit_pulse), 32'd0);
        strobe_commit("coin", set_c);

        // Reset while a full set waits in PEND.
        send_frame(set_a);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rstp", zero_s);
        chk("rstp.valid", 32'(coef_valid), 32'd0);
        chk("rstp.commit", 32'(commit_pulse), 32'd0);
        chk("rstp.err", 32'(err_frame), 32'd0);
        chk("rstp.ready", 32'(bus.s_ready), 32'd1);
        chk("rstp.busy", 32'(busy), 32'd0);
        tick();
        chk("rstp.commit_after", 32'(commit_pulse), 32'd0);
        chk("rstp.err_after", 32'(err_frame), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Error and commit pulses must never overlap.
    always @(negedge clk) begin
        if (!rst && err_frame && commit_pulse) begin
            chk("excl.err_commit", 32'(err_frame & commit_pulse), 32'd0);
        end
    end

endmodule
